// File: rtl/ccr_flag_unit.sv
// Condition-code register behind the ALU: masked flag commit, carry feedback,
// branch-condition evaluation and a saturating shadow stack for interrupt nesting.
module ccr_flag_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [3:0] flag_mask,
  input  logic       ex_valid,
  input  logic       stall,
  input  logic       int_save,
  input  logic       rti_restore,
  input  logic [2:0] cond_sel,
  output logic [3:0] ccr,
  output logic       carry_to_alu,
  output logic       branch_taken,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] PTR_MAX = (PTR_W+1)'(STACK_DEPTH);

  logic [3:0]     slots [STACK_DEPTH];
  logic [PTR_W:0] ptr;
  logic [PTR_W:0] ptr_dec;
  logic [3:0]     upd;
  logic [3:0]     save_val;

  function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                             input logic [3:0] alu,
                                             input logic [3:0] mask);
    return (cur & ~mask) | (alu & mask);
  endfunction

  // Flags packed {Z,N,C,V}: Z=bit3, N=bit2, C=bit1, V=bit0.
  function automatic logic eval_cond(input logic [2:0] sel, input logic [3:0] f);
    logic r;
    case (sel)
      3'b000:  r = 1'b1;
      3'b001:  r = f[3];
      3'b010:  r = ~f[3];
      3'b011:  r = f[1];
      3'b100:  r = ~f[1];
      3'b101:  r = f[2];
      3'b110:  r = f[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign upd          = merge_flags(ccr, {alu_z, alu_n, alu_c, alu_v}, flag_mask);
  assign save_val     = ex_valid ? upd : ccr;
  assign ptr_dec      = ptr - PTR_ONE;
  assign stack_empty  = (ptr == '0);
  assign stack_full   = (ptr == PTR_MAX);
  assign carry_to_alu = ccr[1];
  assign branch_taken = eval_cond(cond_sel, ccr);

  // Commit stage: restore beats save beats plain update; stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr       <= '0;
      ptr       <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) slots[i] <= '0;
    end else if (!stall) begin
      if (rti_restore) begin
        if (!stack_empty) begin
          ccr <= slots[ptr_dec[PTR_W-1:0]];
          ptr <= ptr_dec;
        end else begin
          stack_err <= 1'b1;
        end
        if (int_save) stack_err <= 1'b1;
      end else if (int_save) begin
        ccr <= save_val;
        if (!stack_full) begin
          slots[ptr[PTR_W-1:0]] <= save_val;
          ptr                   <= ptr + PTR_ONE;
        end else begin
          stack_err <= 1'b1;
        end
      end else if (ex_valid) begin
        ccr <= upd;
      end
    end
  end

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Scoreboard bench for ccr_flag_unit: stimulus pushes model expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_ccr_flag_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_z = 0, alu_n = 0, alu_c = 0, alu_v = 0;
  logic [3:0] flag_mask = '0;
  logic       ex_valid = 0, stall = 0, int_save = 0, rti_restore = 0;
  logic [2:0] cond_sel = '0;
  logic [3:0] ccr;
  logic       carry_to_alu, branch_taken, stack_empty, stack_full, stack_err;

  ccr_flag_unit #(.STACK_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .flag_mask(flag_mask), .ex_valid(ex_valid), .stall(stall),
    .int_save(int_save), .rti_restore(rti_restore), .cond_sel(cond_sel),
    .ccr(ccr), .carry_to_alu(carry_to_alu), .branch_taken(branch_taken),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ccr;
    logic       br;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: flags as a 4-bit value, stack as a LIFO queue.
  logic [3:0] m_ccr = '0;
  logic       m_err = 1'b0;
  logic [3:0] m_stk[$];

  function automatic logic cond_ref(input logic [2:0] cs, input logic [3:0] f);
    logic z, n, c, v;
    {z, n, c, v} = f;
    case (cs)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return n;
      3'd6: return v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic ex, input logic [3:0] mask, input logic [3:0] fl,
                      input logic st, input logic sv, input logic rt,
                      input logic [2:0] cs);
    logic [3:0] u;
    exp_t e;
    @(negedge clk);
    ex_valid = ex; flag_mask = mask; {alu_z, alu_n, alu_c, alu_v} = fl;
    stall = st; int_save = sv; rti_restore = rt; cond_sel = cs;
    u = m_ccr;
    for (int i = 0; i < 4; i++) if (mask[i]) u[i] = fl[i];
    if (!st) begin
      if (rt) begin
        if (sv) m_err = 1'b1;
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_ccr = m_stk.pop_back();
      end else if (sv) begin
        if (ex) m_ccr = u;
        if (m_stk.size() < DEPTH) m_stk.push_back(m_ccr);
        else m_err = 1'b1;
      end else if (ex) begin
        m_ccr = u;
      end
    end
    e.ccr = m_ccr; e.br = cond_ref(cs, m_ccr);
    e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == DEPTH); e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic set_idle();
    ex_valid = 0; flag_mask = '0; {alu_z, alu_n, alu_c, alu_v} = '0;
    stall = 0; int_save = 0; rti_restore = 0;
  endtask

  task automatic model_clear();
    m_ccr = '0; m_err = 1'b0; m_stk.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ccr"}, int'(ccr), 0);
    check({tag, "_empty"}, int'(stack_empty), 1);
    check({tag, "_full"}, int'(stack_full), 0);
    check({tag, "_err"}, int'(stack_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    model_clear();
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: output is presented one edge after each issued stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("ccr", int'(ccr), int'(mon_e.ccr));
        check("carry", int'(carry_to_alu), int'(mon_e.ccr[1]));
        check("branch", int'(branch_taken), int'(mon_e.br));
        check("empty", int'(stack_empty), int'(mon_e.empty));
        check("full", int'(stack_full), int'(mon_e.full));
        check("err", int'(stack_err), int'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Full-mask update, then CLRC, then save/restore round trip.
    step(1, 4'b1111, 4'b0110, 0, 0, 0, 3'b101);
    step(1, 4'b0010, 4'b0000, 0, 0, 0, 3'b100);
    step(1, 4'b1111, 4'b1000, 0, 0, 0, 3'b001);
    step(1, 4'b1111, 4'b0011, 0, 1, 0, 3'b011);
    step(1, 4'b1111, 4'b1100, 0, 0, 0, 3'b010);
    step(0, 4'b0000, 4'b0000, 0, 0, 1, 3'b110);

    // Overfill then drain in LIFO order.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 4'b1111, 4'(k + 1), 0, 1, 0, 3'(k));
    for (int k = 0; k < 4; k++) step(0, 4'b0000, 4'b0000, 0, 0, 1, 3'(k + 3));

    // Underflow, and restore/save conflict.
    do_reset();
    step(1, 4'b1111, 4'b1010, 0, 0, 0, 3'b000);
    step(0, 4'b0000, 4'b0000, 0, 0, 1, 3'b001);
    do_reset();
    step(1, 4'b1111, 4'b0101, 0, 1, 0, 3'b000);
    step(1, 4'b1111, 4'b1111, 0, 1, 1, 3'b110);

    // Stall blocks update and push.
    do_reset();
    step(1, 4'b1111, 4'b1001, 0, 0, 0, 3'b001);
    step(1, 4'b1111, 4'b0110, 1, 1, 0, 3'b001);
    step(0, 4'b0000, 4'b0000, 1, 0, 1, 3'b110);

    // Asynchronous reset mid-cycle, no clock edge needed.
    step(1, 4'b1111, 4'b1110, 0, 1, 0, 3'b000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("async");
    set_idle();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with periodic resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset();
      else step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, 3'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
